// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-to-unified-memory arbitration path.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [2:0]  SIZE_WORD         = 3'b010;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for one memory access: counts cycles without ack and flags expiry
// at TIMEOUT_CYC. An ack arriving in the expiry cycle suppresses the abort.
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic ack,
  output logic expired
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] wait_cnt;

  // Saturates at CNT_MAX so a stuck request can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (count_en && !ack && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = count_en && !ack && (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU's data access and instruction fetch onto one memory port,
// data first, freezing the pipeline until both have completed or been aborted.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr_Addr,
  output logic [31:0] INSTRUCTION,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  input  logic        d_rd_en,
  input  logic        d_wr_en,
  output logic [31:0] d_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        MEM_req,
  output logic        MEM_we,
  output logic [31:0] MEM_addr,
  output logic [31:0] MEM_wdata,
  output logic [2:0]  MEM_size,
  input  logic        MEM_ack,
  input  logic [31:0] MEM_rdata
);

  arb_state_t  state, state_next;
  logic [31:0] instr_addr_q, d_addr_q, d_wdata_q;
  logic [2:0]  d_type_q;
  logic        is_wr, is_rd;
  logic        in_access, expired, access_end;

  assign in_access  = (state == ST_DATA) || (state == ST_FETCH);
  assign access_end = in_access && (MEM_ack || expired);

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clock   (CLK),
    .reset   (Reset),
    .clear   (!in_access || (state_next != state)),
    .count_en(in_access),
    .ack     (MEM_ack),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = (d_rd_en || d_wr_en) ? ST_DATA : ST_FETCH;
      ST_DATA:  if (access_end) state_next = ST_FETCH;
      ST_FETCH: if (access_end) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs decode only from state and the request latched in IDLE,
  // so they stay stable for the whole request regardless of CPU input changes.
  always_comb begin
    MEM_req   = 1'b0;
    MEM_we    = 1'b0;
    MEM_addr  = '0;
    MEM_wdata = '0;
    MEM_size  = '0;
    stall     = (state != ST_DONE);
    case (state)
      ST_DATA: begin
        MEM_req   = 1'b1;
        MEM_we    = is_wr;
        MEM_addr  = d_addr_q;
        MEM_wdata = d_wdata_q;
        MEM_size  = d_type_q;
      end
      ST_FETCH: begin
        MEM_req  = 1'b1;
        MEM_addr = instr_addr_q;
        MEM_size = SIZE_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      instr_addr_q <= '0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_type_q     <= '0;
      is_wr        <= 1'b0;
      is_rd        <= 1'b0;
      INSTRUCTION  <= NOP_INSTR;
      d_rdata      <= '0;
      bus_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          instr_addr_q <= Instr_Addr;
          d_addr_q     <= d_addr;
          d_wdata_q    <= d_wdata;
          d_type_q     <= d_type;
          is_wr        <= d_wr_en;
          is_rd        <= d_rd_en && !d_wr_en;
        end
        ST_DATA: begin
          if (MEM_ack) begin
            d_rdata <= is_rd ? MEM_rdata : '0;
          end else if (expired) begin
            d_rdata <= '0;
            bus_err <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (MEM_ack) begin
            INSTRUCTION <= MEM_rdata;
          end else if (expired) begin
            INSTRUCTION <= NOP_INSTR;
            bus_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small wait-state memory model.
module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Instr_Addr, d_addr, d_wdata;
  logic [2:0]  d_type;
  logic        d_rd_en, d_wr_en;
  logic [31:0] INSTRUCTION, d_rdata;
  logic        stall, bus_err;
  logic        MEM_req, MEM_we;
  logic [31:0] MEM_addr, MEM_wdata;
  logic [2:0]  MEM_size;
  logic        MEM_ack;
  logic [31:0] MEM_rdata;

  logic        model_ack = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        stray_ack = 1'b0;
  logic [31:0] stray_rdata = '0;
  logic        ack_enable = 1'b1;
  int          mem_wait = 0;
  int          wait_seen = 0;
  logic [31:0] mem [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          first_req_cycle;
  logic [31:0] first_addr, first_wdata, last_addr;
  logic        first_we;
  logic [2:0]  first_size;

  assign MEM_ack   = model_ack | stray_ack;
  assign MEM_rdata = stray_ack ? stray_rdata : model_rdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(
    .TIMEOUT_CYC(4),
    .NOP_INSTR  (NOP)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Instr_Addr (Instr_Addr),
    .INSTRUCTION(INSTRUCTION),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_type     (d_type),
    .d_rd_en    (d_rd_en),
    .d_wr_en    (d_wr_en),
    .d_rdata    (d_rdata),
    .stall      (stall),
    .bus_err    (bus_err),
    .MEM_req    (MEM_req),
    .MEM_we     (MEM_we),
    .MEM_addr   (MEM_addr),
    .MEM_wdata  (MEM_wdata),
    .MEM_size   (MEM_size),
    .MEM_ack    (MEM_ack),
    .MEM_rdata  (MEM_rdata)
  );

  // Memory model: acks after mem_wait idle request cycles, stores write through.
  always @(negedge CLK) begin
    if (MEM_req && ack_enable) begin
      if (wait_seen == mem_wait) begin
        model_ack = 1'b1;
        wait_seen = 0;
        if (MEM_we) begin
          mem[MEM_addr] = MEM_wdata;
          model_rdata   = 32'hFFFFFFFF;
        end else begin
          model_rdata = mem.exists(MEM_addr) ? mem[MEM_addr] : 32'h0;
        end
      end else begin
        model_ack = 1'b0;
        wait_seen++;
      end
    end else begin
      model_ack = 1'b0;
      wait_seen = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ia, input logic rd, input logic wr,
                               input logic [31:0] da, input logic [31:0] wd,
                               input logic [2:0] dt, input int wait_n);
    Instr_Addr = ia;
    d_rd_en    = rd;
    d_wr_en    = wr;
    d_addr     = da;
    d_wdata    = wd;
    d_type     = dt;
    mem_wait   = wait_n;
  endtask

  // Called in the IDLE cycle (cycle 1); returns in the DONE cycle.
  task automatic runStep(input string tag, input int exp_cycle);
    int  cyc = 1;
    bit  seen = 0;
    first_req_cycle = 0;
    while (cyc < 40) begin
      stepCycle();
      cyc++;
      if (MEM_req) begin
        if (!seen) begin
          seen            = 1;
          first_req_cycle = cyc;
          first_addr      = MEM_addr;
          first_we        = MEM_we;
          first_size      = MEM_size;
          first_wdata     = MEM_wdata;
        end
        last_addr = MEM_addr;
      end
      if (!stall) break;
    end
    checkOutput({tag, "_done_cycle"}, cyc, exp_cycle);
  endtask

  task automatic finishStep(input string tag, input logic [31:0] exp_instr);
    stepCycle();
    checkOutput({tag, "_idle_stall"}, {31'b0, stall}, 32'd1);
    checkOutput({tag, "_idle_instr_hold"}, INSTRUCTION, exp_instr);
  endtask

  initial begin
    mem[32'h40]  = 32'h00500093;
    mem[32'h44]  = 32'h00A00113;
    mem[32'h48]  = 32'h01400193;
    mem[32'h4C]  = 32'h00208233;
    mem[32'h50]  = 32'h002082B3;
    mem[32'h54]  = 32'h00308333;
    mem[32'h58]  = 32'h004083B3;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h10C] = 32'hA5A55A5A;
    mem[32'h108] = 32'h11111111;

    Reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 0);
    repeat (2) stepCycle();
    checkOutput("reset_stall", {31'b0, stall}, 32'd1);
    checkOutput("reset_mem_req", {31'b0, MEM_req}, 32'd0);
    checkOutput("reset_mem_addr", MEM_addr, 32'h0);
    checkOutput("reset_instr", INSTRUCTION, NOP);
    checkOutput("reset_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("reset_d_rdata", d_rdata, 32'h0);

    // Fetch only, zero wait
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 0);
    Reset = 1'b0;
    runStep("fetch0", 3);
    checkOutput("fetch0_req_cycle", first_req_cycle, 32'd2);
    checkOutput("fetch0_addr", first_addr, 32'h40);
    checkOutput("fetch0_size", {29'b0, first_size}, 32'd2);
    checkOutput("fetch0_we", {31'b0, first_we}, 32'd0);
    checkOutput("fetch0_instr", INSTRUCTION, 32'h00500093);
    finishStep("fetch0", 32'h00500093);

    // Load plus fetch, two wait cycles each
    applyStimulus(32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 2);
    runStep("load2w", 8);
    checkOutput("load2w_first_addr", first_addr, 32'h100);
    checkOutput("load2w_last_addr", last_addr, 32'h44);
    checkOutput("load2w_d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("load2w_instr", INSTRUCTION, 32'h00A00113);
    finishStep("load2w", 32'h00A00113);
    checkOutput("load2w_rdata_hold", d_rdata, 32'hDEADBEEF);

    // Byte store
    applyStimulus(32'h48, 1'b0, 1'b1, 32'h104, 32'h12345678, 3'b000, 0);
    runStep("store", 4);
    checkOutput("store_we", {31'b0, first_we}, 32'd1);
    checkOutput("store_size", {29'b0, first_size}, 32'd0);
    checkOutput("store_addr", first_addr, 32'h104);
    checkOutput("store_wdata", first_wdata, 32'h12345678);
    checkOutput("store_d_rdata", d_rdata, 32'h0);
    checkOutput("store_mem", mem[32'h104], 32'h12345678);
    finishStep("store", 32'h01400193);

    // Load back the stored word
    applyStimulus(32'h4C, 1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 0);
    runStep("reload", 4);
    checkOutput("reload_d_rdata", d_rdata, 32'h12345678);
    finishStep("reload", 32'h00208233);

    // Read and write both requested: treated as a store
    applyStimulus(32'h50, 1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 3'b010, 0);
    runStep("rdwr", 4);
    checkOutput("rdwr_we", {31'b0, first_we}, 32'd1);
    checkOutput("rdwr_d_rdata", d_rdata, 32'h0);
    checkOutput("rdwr_mem", mem[32'h108], 32'hCAFEF00D);
    finishStep("rdwr", 32'h002082B3);

    // Ack arriving exactly at the timeout cycle wins
    applyStimulus(32'h54, 1'b1, 1'b0, 32'h10C, 32'h0, 3'b010, 4);
    runStep("ack_at_limit", 12);
    checkOutput("ack_at_limit_d_rdata", d_rdata, 32'hA5A55A5A);
    checkOutput("ack_at_limit_instr", INSTRUCTION, 32'h00308333);
    checkOutput("ack_at_limit_bus_err", {31'b0, bus_err}, 32'd0);
    finishStep("ack_at_limit", 32'h00308333);

    // Hung memory: both accesses abort
    ack_enable = 1'b0;
    applyStimulus(32'h58, 1'b1, 1'b0, 32'h10C, 32'h0, 3'b010, 0);
    runStep("timeout", 12);
    checkOutput("timeout_d_rdata", d_rdata, 32'h0);
    checkOutput("timeout_instr", INSTRUCTION, NOP);
    checkOutput("timeout_bus_err", {31'b0, bus_err}, 32'd1);
    finishStep("timeout", NOP);

    // bus_err stays set through a normal step
    ack_enable = 1'b1;
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 0);
    runStep("sticky", 3);
    checkOutput("sticky_bus_err", {31'b0, bus_err}, 32'd1);
    checkOutput("sticky_instr", INSTRUCTION, 32'h00500093);
    finishStep("sticky", 32'h00500093);

    // Reset during DATA, then a stray ack while idle
    ack_enable = 1'b0;
    applyStimulus(32'h50, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0);
    stepCycle();
    checkOutput("rst_mid_req_before", {31'b0, MEM_req}, 32'd1);
    Reset = 1'b1;
    stepCycle();
    checkOutput("rst_mid_req_after", {31'b0, MEM_req}, 32'd0);
    checkOutput("rst_mid_stall", {31'b0, stall}, 32'd1);
    checkOutput("rst_mid_bus_err", {31'b0, bus_err}, 32'd0);
    Reset       = 1'b0;
    d_rd_en     = 1'b0;
    stray_rdata = 32'hBADBAD00;
    stray_ack   = 1'b1;
    stepCycle();
    stray_ack = 1'b0;
    checkOutput("stray_instr", INSTRUCTION, NOP);
    checkOutput("stray_d_rdata", d_rdata, 32'h0);
    checkOutput("stray_fetch_req", {31'b0, MEM_req}, 32'd1);
    checkOutput("stray_fetch_addr", MEM_addr, 32'h50);
    ack_enable = 1'b1;
    stepCycle();
    checkOutput("post_stray_stall", {31'b0, stall}, 32'd0);
    checkOutput("post_stray_instr", INSTRUCTION, 32'h002082B3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
